axi_lite_sram: RTL and testbench

- AXI4-Lite memory slave sitting directly downstream of the 2-master AXI4-Lite arbiter; it is the slave that consumes the arbitrated request stream.
- Provides a word-addressed SRAM with byte-masked writes.
- Read and write channels are independent; each has its own FSM.
- Response latency is programmable (fixed or LFSR-random) to stress the arbiter and the masters' handshakes.

---
 rtl/axi_lite_sram_if.sv | 30 +++
 rtl/axi_lite_sram.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_sram.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the SRAM slave.
interface axi_lite_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-addressed SRAM slave with byte-masked writes and programmable
// (fixed or LFSR-random) response latency on independent read/write FSMs.
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RAND_DELAY  = 0,
  parameter int unsigned FIXED_DELAY = 1,
  parameter int unsigned DELAY_BITS  = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  axi_lite_sram_if.slave axi
);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  D_MASK = 8'((1 << DELAY_BITS) - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] r_mem [DEPTH_WORDS];

  // Shared delay source: x^8+x^6+x^5+x^4+1, free-running outside reset.
  logic [7:0] r_lfsr;
  logic       w_fb;
  logic [7:0] w_delay;
  assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_delay = (RAND_DELAY != 0) ? (r_lfsr & D_MASK) : 8'(FIXED_DELAY);

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  // Read channel
  logic [1:0]       r_rd_state;
  logic [7:0]       r_rd_cnt;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_rd_ok;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;
  logic [31:0]      w_rd_off;
  logic             w_rd_ok;

  assign w_rd_off    = axi.araddr - BASE_ADDR;
  assign w_rd_ok     = (axi.araddr >= BASE_ADDR) && (w_rd_off < SPAN);
  assign axi.arready = (r_rd_state == R_IDLE);
  assign axi.rvalid  = (r_rd_state == R_RESP);
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_rd_idx   <= '0;
      r_rd_ok    <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      case (r_rd_state)
        R_IDLE: if (axi.arvalid) begin
          r_rd_idx   <= w_rd_off[IDX_W+1:2];
          r_rd_ok    <= w_rd_ok;
          r_rd_cnt   <= w_delay;
          r_rd_state <= R_WAIT;
        end
        R_WAIT: if (r_rd_cnt == 8'd0) begin
          r_rdata    <= r_rd_ok ? r_mem[r_rd_idx] : 32'h0;
          r_rresp    <= r_rd_ok ? 2'b00 : 2'b11;
          r_rd_state <= R_RESP;
        end else begin
          r_rd_cnt <= r_rd_cnt - 8'd1;
        end
        R_RESP: if (axi.rready) r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write channel: AW and W latch independently, then share one delay/commit.
  logic [1:0]       r_wr_state;
  logic [7:0]       r_wr_cnt;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_wr_ok;
  logic [31:0]      r_wr_data;
  logic [3:0]       r_wr_mask;
  logic             r_aw_held;
  logic             r_w_held;
  logic [1:0]       r_bresp;
  logic [31:0]      w_wr_off;
  logic             w_wr_ok;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_both;
  logic             w_commit;

  assign w_wr_off    = axi.awaddr - BASE_ADDR;
  assign w_wr_ok     = (axi.awaddr >= BASE_ADDR) && (w_wr_off < SPAN);
  assign axi.awready = (r_wr_state == W_IDLE) && !r_aw_held;
  assign axi.wready  = (r_wr_state == W_IDLE) && !r_w_held;
  assign axi.bvalid  = (r_wr_state == W_RESP);
  assign axi.bresp   = r_bresp;
  assign w_aw_hs     = axi.awvalid && axi.awready;
  assign w_w_hs      = axi.wvalid && axi.wready;
  assign w_both      = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_commit    = !reset && (r_wr_state == W_WAIT) && (r_wr_cnt == 8'd0) && r_wr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_wr_idx   <= '0;
      r_wr_ok    <= 1'b0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bresp    <= 2'b00;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wr_idx  <= w_wr_off[IDX_W+1:2];
            r_wr_ok   <= w_wr_ok;
            r_aw_held <= 1'b1;
          end
          if (w_w_hs) begin
            r_wr_data <= axi.wdata;
            r_wr_mask <= axi.wmask;
            r_w_held  <= 1'b1;
          end
          if (w_both) begin
            r_wr_cnt   <= w_delay;
            r_wr_state <= W_WAIT;
          end
        end
        W_WAIT: if (r_wr_cnt == 8'd0) begin
          r_bresp    <= r_wr_ok ? 2'b00 : 2'b11;
          r_wr_state <= W_RESP;
        end else begin
          r_wr_cnt <= r_wr_cnt - 8'd1;
        end
        W_RESP: if (axi.bready) begin
          r_aw_held  <= 1'b0;
          r_w_held   <= 1'b0;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Same-edge read capture sees the pre-commit word.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wr_mask[b]) r_mem[r_wr_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed tests on a fixed-delay instance,
// then a scoreboarded random mix on an LFSR-delay instance.
module tb_axi_lite_sram;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wmask = '0;
  logic        sel = 1'b0;

  axi_lite_sram_if bf ();
  axi_lite_sram_if br ();

  assign bf.araddr = araddr;  assign br.araddr = araddr;
  assign bf.arvalid = arvalid; assign br.arvalid = arvalid;
  assign bf.rready = rready;  assign br.rready = rready;
  assign bf.awaddr = awaddr;  assign br.awaddr = awaddr;
  assign bf.awvalid = awvalid; assign br.awvalid = awvalid;
  assign bf.wdata = wdata;    assign br.wdata = wdata;
  assign bf.wmask = wmask;    assign br.wmask = wmask;
  assign bf.wvalid = wvalid;  assign br.wvalid = wvalid;
  assign bf.bready = bready;  assign br.bready = bready;

  axi_lite_sram #(.RAND_DELAY(0), .FIXED_DELAY(1)) dut_fix (.clk(clk), .reset(reset), .axi(bf));
  axi_lite_sram #(.RAND_DELAY(1), .DELAY_BITS(3)) dut_rnd (.clk(clk), .reset(reset), .axi(br));

  logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp;
  assign o_arready = sel ? br.arready : bf.arready;
  assign o_rvalid  = sel ? br.rvalid  : bf.rvalid;
  assign o_rdata   = sel ? br.rdata   : bf.rdata;
  assign o_rresp   = sel ? br.rresp   : bf.rresp;
  assign o_awready = sel ? br.awready : bf.awready;
  assign o_wready  = sel ? br.wready  : bf.wready;
  assign o_bvalid  = sel ? br.bvalid  : bf.bvalid;
  assign o_bresp   = sel ? br.bresp   : bf.bresp;

  // Reference delay source: x^8+x^6+x^5+x^4+1 from seed A5, stepping each non-reset cycle.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int checks = 0;
  int failures = 0;
  int min_lat = 100;
  int max_lat = 0;
  logic [31:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];
  int          exp_rlat_q[$];
  int          exp_blat_q[$];
  logic [31:0] rm [8];

  function automatic int exp_delay();
    return sel ? int'(m_lfsr[2:0]) : 1;
  endfunction

  // All tasks enter and leave at a falling edge.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    int n, lat;
    logic [31:0] d0;
    logic [1:0]  r0, er;
    logic [31:0] ed;
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!o_arready && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (o_arready !== 1'b1) begin failures++; $display("FAIL ar_accept arready=%b want 1", o_arready); end
    exp_rdata_q.push_back(exp_data);
    exp_rresp_q.push_back(exp_resp);
    exp_rlat_q.push_back(2 + exp_delay());
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    checks++;
    if (o_arready !== 1'b0) begin failures++; $display("FAIL ar_drop arready=%b want 0", o_arready); end
    while (!o_rvalid && n < 40) begin @(negedge clk); n++; end
    lat = exp_rlat_q.pop_front();
    ed = exp_rdata_q.pop_front();
    er = exp_rresp_q.pop_front();
    checks++;
    if (o_rvalid !== 1'b1 || n != lat) begin
      failures++; $display("FAIL r_latency addr=%h got=%0d want=%0d", addr, n, lat);
    end
    if (sel) begin
      if (n < min_lat) min_lat = n;
      if (n > max_lat) max_lat = n;
    end
    checks++;
    if (o_rdata !== ed || o_rresp !== er) begin
      failures++; $display("FAIL r_data addr=%h got=%h/%b want=%h/%b", addr, o_rdata, o_rresp, ed, er);
    end
    d0 = o_rdata;
    r0 = o_rresp;
    if (hold > 0) begin
      arvalid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (o_rvalid !== 1'b1 || o_rdata !== d0 || o_rresp !== r0 || o_arready !== 1'b0) begin
          failures++;
          $display("FAIL r_hold cyc=%0d got rv=%b d=%h r=%b ar=%b want 1/%h/%b/0",
                   i, o_rvalid, o_rdata, o_rresp, o_arready, d0, r0);
        end
      end
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    arvalid = 1'b0;
    checks++;
    if (o_rvalid !== 1'b0 || o_arready !== 1'b1) begin
      failures++; $display("FAIL r_done rvalid=%b arready=%b want 0/1", o_rvalid, o_arready);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input int lead, input logic [1:0] exp_resp);
    int n, lat;
    logic [1:0] er;
    awaddr = addr;
    wdata = data;
    wmask = mask;
    wvalid = 1'b1;
    n = 0;
    while (!o_wready && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (o_wready !== 1'b1) begin failures++; $display("FAIL w_accept wready=%b want 1", o_wready); end
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      wvalid = 1'b0;
      checks++;
      if (o_wready !== 1'b0 || o_awready !== 1'b1) begin
        failures++; $display("FAIL w_held wready=%b awready=%b want 0/1", o_wready, o_awready);
      end
    end
    awvalid = 1'b1;
    checks++;
    if (o_awready !== 1'b1) begin failures++; $display("FAIL aw_accept awready=%b want 1", o_awready); end
    exp_bresp_q.push_back(exp_resp);
    exp_blat_q.push_back(2 + exp_delay());
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 1;
    checks++;
    if (o_awready !== 1'b0 || o_wready !== 1'b0) begin
      failures++; $display("FAIL aw_w_drop awready=%b wready=%b want 0/0", o_awready, o_wready);
    end
    while (!o_bvalid && n < 40) begin @(negedge clk); n++; end
    lat = exp_blat_q.pop_front();
    er = exp_bresp_q.pop_front();
    checks++;
    if (o_bvalid !== 1'b1 || n != lat) begin
      failures++; $display("FAIL b_latency addr=%h got=%0d want=%0d", addr, n, lat);
    end
    if (sel) begin
      if (n < min_lat) min_lat = n;
      if (n > max_lat) max_lat = n;
    end
    checks++;
    if (o_bresp !== er) begin failures++; $display("FAIL bresp addr=%h got=%b want=%b", addr, o_bresp, er); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (o_bvalid !== 1'b0 || o_awready !== 1'b1 || o_wready !== 1'b1) begin
      failures++;
      $display("FAIL b_done bvalid=%b awready=%b wready=%b want 0/1/1", o_bvalid, o_awready, o_wready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_arready, o_awready, o_wready} !== 3'b111) begin
      failures++; $display("FAIL rst_ready got=%b want=111", {o_arready, o_awready, o_wready});
    end
    checks++;
    if ({o_rvalid, o_bvalid} !== 2'b00) begin
      failures++; $display("FAIL rst_valid got=%b want=00", {o_rvalid, o_bvalid});
    end
    checks++;
    if (o_rdata !== 32'h0 || o_rresp !== 2'b00 || o_bresp !== 2'b00) begin
      failures++; $display("FAIL rst_data got=%h/%b/%b want=0/00/00", o_rdata, o_rresp, o_bresp);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_arready, o_awready, o_wready, o_rvalid, o_bvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL post_rst got=%b want=11100", {o_arready, o_awready, o_wready, o_rvalid, o_bvalid});
    end
  endtask

  task automatic test_write_read();
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
  endtask

  task automatic test_byte_mask();
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 2'b00);
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 0);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, 2'b00);
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 0);
  endtask

  task automatic test_aw_w_order();
    do_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 3, 2'b00);
    do_write(32'h8000_0024, 32'h0BAD_C0DE, 4'hF, 0, 2'b00);
    do_read(32'h8000_0020, 32'hCAFE_F00D, 2'b00, 0);
    do_read(32'h8000_0024, 32'h0BAD_C0DE, 2'b00, 0);
  endtask

  task automatic test_decerr();
    do_write(32'h8000_0000, 32'h0102_0304, 4'hF, 0, 2'b00);
    do_read(32'h7FFF_FFFC, 32'h0, 2'b11, 0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 2'b11);
    do_read(32'h8000_0000, 32'h0102_0304, 2'b00, 0);
    do_write(32'h8000_3FFF, 32'hA5A5_5A5A, 4'hF, 0, 2'b00);
    do_read(32'h8000_3FFC, 32'hA5A5_5A5A, 2'b00, 0);
  endtask

  task automatic test_rready_hold();
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 5);
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    araddr = 32'h8000_0010;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (o_arready !== 1'b1 || o_rvalid !== 1'b0) begin
      failures++; $display("FAIL mid_rst arready=%b rvalid=%b want 1/0", o_arready, o_rvalid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_rvalid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_rvalid got=%b want=0", seen); end
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 0);
  endtask

  task automatic wait_lfsr(input logic [2:0] t);
    int n = 0;
    while (m_lfsr[2:0] != t && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic test_random();
    int k;
    logic [31:0] addr, d;
    logic [3:0]  m;
    logic        oor;
    sel = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      wait_lfsr(3'(i % 8));
      if (i < 8) begin
        rm[i] = $urandom;
        do_write(32'h8000_0100 + 32'(4 * i), rm[i], 4'hF, 0, 2'b00);
      end else begin
        k = $urandom_range(0, 8);
        oor = (k == 8);
        addr = oor ? ((i % 2 == 0) ? 32'h8000_4000 : 32'h7FFF_FFFC) : 32'h8000_0100 + 32'(4 * k);
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          m = 4'($urandom_range(0, 15));
          do_write(addr, d, m, 0, oor ? 2'b11 : 2'b00);
          if (!oor) for (int b = 0; b < 4; b++) if (m[b]) rm[k][8*b +: 8] = d[8*b +: 8];
        end else begin
          do_read(addr, oor ? 32'h0 : rm[k], oor ? 2'b11 : 2'b00, 0);
        end
      end
    end
    checks++;
    if (min_lat != 2 || max_lat != 9) begin
      failures++; $display("FAIL lat_span got=%0d..%0d want=2..9", min_lat, max_lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_mask();
    test_aw_w_order();
    test_decerr();
    test_rready_hold();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
